// File: rtl/seq_calculator_pkg.sv
// Shared definitions for the sequential calculator: opcodes, FSM states
// and the bit positions of the compare result.
package calc_defs;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  localparam int CMP_LT = 0;
  localparam int CMP_EQ = 1;
  localparam int CMP_GT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Divide by zero never enters the iterative path; it resolves in one cycle.
  function automatic logic needs_iter(input logic [2:0] op, input logic b_is_zero);
    return (op == OP_MUL) || ((op == OP_DIV) && !b_is_zero);
  endfunction

endpackage

// File: rtl/calc_muldiv.sv
// Iterative unsigned multiply (shift-add, LSB first) and restoring divide
// (MSB first), one bit per clock, W iterations per operation.
module calc_muldiv
  import calc_defs::*;
#(
  parameter int W  = 4,
  parameter int OW = 2 * W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic          i_is_div,
  input  logic [W-1:0]  i_a,
  input  logic [W-1:0]  i_b,
  output logic          o_busy,
  output logic          o_done,
  output logic [OW-1:0] o_result
);

  localparam logic [W-1:0] LAST = W'(W - 1);

  logic          r_busy;
  logic          r_is_div;
  logic [W-1:0]  r_cnt;
  logic [OW-1:0] r_p;
  logic [OW-1:0] r_m;
  logic [W-1:0]  r_q;
  logic [W-1:0]  r_r;

  logic [W:0]    w_rem_sh;
  logic          w_fits;
  logic [W-1:0]  w_diff;
  logic [OW-1:0] w_p_next;
  logic [OW-1:0] w_m_next;
  logic [W-1:0]  w_q_next;
  logic [W-1:0]  w_r_next;

  // r_q doubles as multiplier shift register (mul) and dividend/quotient (div);
  // r_m holds the shifted multiplicand (mul) or the divisor in its low bits (div).
  assign w_rem_sh = {r_r, r_q[W-1]};
  assign w_fits   = (w_rem_sh >= {1'b0, r_m[W-1:0]});
  assign w_diff   = w_rem_sh[W-1:0] - r_m[W-1:0];

  always_comb begin
    w_p_next = r_p;
    w_m_next = r_m;
    w_q_next = r_q;
    w_r_next = r_r;
    if (r_is_div) begin
      w_r_next = w_fits ? w_diff : w_rem_sh[W-1:0];
      w_q_next = {r_q[W-2:0], w_fits};
    end else begin
      w_p_next = r_q[0] ? (r_p + r_m) : r_p;
      w_m_next = r_m << 1;
      w_q_next = r_q >> 1;
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_busy && (r_cnt == LAST);
  assign o_result = r_is_div ? {w_r_next, w_q_next} : w_p_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_is_div <= 1'b0;
      r_cnt    <= '0;
      r_p      <= '0;
      r_m      <= '0;
      r_q      <= '0;
      r_r      <= '0;
    end else if (i_start && !r_busy) begin
      r_busy   <= 1'b1;
      r_is_div <= i_is_div;
      r_cnt    <= '0;
      r_p      <= '0;
      r_m      <= i_is_div ? OW'(i_b) : OW'(i_a);
      r_q      <= i_is_div ? i_a : i_b;
      r_r      <= '0;
    end else if (r_busy) begin
      r_p <= w_p_next;
      r_m <= w_m_next;
      r_q <= w_q_next;
      r_r <= w_r_next;
      if (o_done) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_calculator.sv
// Sequential calculator: single-cycle add/sub/logic/cmp, iterative mul/div.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
module seq_calculator
  import calc_defs::*;
#(
  parameter int W  = 4,
  parameter int OW = 2 * W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [2:0]    oper,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [OW-1:0] out,
  output logic          err,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    o_dbg_state
);

  state_t        r_state;
  state_t        w_next;
  logic [OW-1:0] r_out;
  logic          r_err;

  logic          w_accept;
  logic          w_b_zero;
  logic          w_iter;
  logic [OW-1:0] w_single;
  logic          w_single_err;
  logic          w_md_busy;
  logic          w_md_done;
  logic [OW-1:0] w_md_result;

  assign w_accept = (r_state == ST_IDLE) && in_valid;
  assign w_b_zero = (b == '0);
  assign w_iter   = needs_iter(oper, w_b_zero);

  always_comb begin
    w_single     = '0;
    w_single_err = 1'b0;
    case (oper)
      OP_ADD: w_single = OW'(a) + OW'(b);
      // Subtracting zero-extended operands at full width yields the sign-extended difference.
      OP_SUB: w_single = OW'(a) - OW'(b);
      OP_AND: w_single = OW'(a & b);
      OP_OR:  w_single = OW'(a | b);
      OP_XOR: w_single = OW'(a ^ b);
      OP_CMP: begin
        w_single[CMP_GT] = (a > b);
        w_single[CMP_EQ] = (a == b);
        w_single[CMP_LT] = (a < b);
      end
      OP_DIV: begin
        w_single     = '1;
        w_single_err = 1'b1;
      end
      default: w_single = '0;
    endcase
  end

  calc_muldiv #(.W(W), .OW(OW)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_accept && w_iter),
    .i_is_div (oper == OP_DIV),
    .i_a      (a),
    .i_b      (b),
    .o_busy   (w_md_busy),
    .o_done   (w_md_done),
    .o_result (w_md_result)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid) w_next = w_iter ? ST_BUSY : ST_DONE;
      ST_BUSY: if (w_md_done) w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_out   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept && !w_iter) begin
        r_out <= w_single;
        r_err <= w_single_err;
      end else if ((r_state == ST_BUSY) && w_md_busy && w_md_done) begin
        r_out <= w_md_result;
        r_err <= 1'b0;
      end
    end
  end

  assign in_ready    = (r_state == ST_IDLE);
  assign out_valid   = (r_state == ST_DONE);
  assign out         = r_out;
  assign err         = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seq_calculator.sv
// Directed self-checking bench for seq_calculator at W=4.
module tb_seq_calculator;
  import calc_defs::*;

  localparam int W  = 4;
  localparam int OW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  a, b;
  logic [2:0]    oper;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] out;
  logic          err;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [OW-1:0] exp_q[$];

  seq_calculator #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .a           (a),
    .b           (b),
    .oper        (oper),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out         (out),
    .err         (err),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One full transaction: issue, measure latency, optionally stall, then release.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [2:0] top,
                       input logic [OW-1:0] eo, input logic ee, input int elat, input int hold);
    int lat;
    int n_low;
    logic [OW-1:0] exp_v;
    exp_q.push_back(eo);
    @(negedge clk);
    check_eq("ready_before_op", in_ready, 1);
    a = ta; b = tb_v; oper = top; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom_range(0, 15));
    b = W'($urandom_range(0, 15));
    oper = 3'($urandom_range(0, 7));
    lat = 1;
    n_low = 0;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      if (!in_ready) n_low++;
      in_valid = 1'($urandom_range(0, 1));
      lat++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_eq("latency", lat, elat);
    check_eq("busy_ready_low", n_low, elat - 1);
    exp_v = exp_q.pop_front();
    check_eq("out", out, exp_v);
    check_eq("err", err, ee);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      a = W'($urandom_range(0, 15));
      oper = 3'($urandom_range(0, 7));
      @(negedge clk);
      check_eq("hold_out", out, exp_v);
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check_eq("released_valid", out_valid, 0);
    check_eq("released_ready", in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; a = '0; b = '0; oper = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out", out, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_state", dbg_state, ST_IDLE);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("ready_after_rst", in_ready, 1);

    do_op(4'd9,  4'd3,  OP_ADD, 8'h0C, 1'b0, 1, 0);
    do_op(4'd9,  4'd3,  OP_SUB, 8'h06, 1'b0, 1, 0);
    do_op(4'd3,  4'd9,  OP_SUB, 8'hFA, 1'b0, 1, 0);
    do_op(4'd9,  4'd3,  OP_CMP, 8'h04, 1'b0, 1, 0);
    do_op(4'd5,  4'd5,  OP_CMP, 8'h02, 1'b0, 1, 0);
    do_op(4'd2,  4'd7,  OP_CMP, 8'h01, 1'b0, 1, 0);
    do_op(4'd9,  4'd3,  OP_MUL, 8'h1B, 1'b0, 5, 10);
    do_op(4'd9,  4'd3,  OP_DIV, 8'h03, 1'b0, 5, 0);
    do_op(4'd9,  4'd0,  OP_DIV, 8'hFF, 1'b1, 1, 2);
    do_op(4'd9,  4'd3,  OP_AND, 8'h01, 1'b0, 1, 0);
    do_op(4'd9,  4'd3,  OP_OR,  8'h0B, 1'b0, 1, 0);
    do_op(4'd9,  4'd3,  OP_XOR, 8'h0A, 1'b0, 1, 0);
    do_op(4'd15, 4'd15, OP_ADD, 8'h1E, 1'b0, 1, 0);
    do_op(4'd15, 4'd15, OP_MUL, 8'hE1, 1'b0, 5, 0);
    do_op(4'd15, 4'd4,  OP_DIV, 8'h33, 1'b0, 5, 0);
    do_op(4'd3,  4'd9,  OP_DIV, 8'h30, 1'b0, 5, 0);
    do_op(4'd0,  4'd15, OP_SUB, 8'hF1, 1'b0, 1, 0);

    // Reset during the second BUSY cycle of a multiply.
    @(negedge clk);
    a = 4'd9; b = 4'd3; oper = OP_MUL; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check_eq("abort_busy_state", dbg_state, ST_BUSY);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("abort_valid", out_valid, 0);
    check_eq("abort_out", out, 0);
    check_eq("abort_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("abort_no_result", out_valid, 0);
    end
    do_op(4'd1, 4'd1, OP_ADD, 8'h02, 1'b0, 1, 0);

    // Reset wins over out_ready in the same cycle while in DONE.
    @(negedge clk);
    a = 4'd2; b = 4'd3; oper = OP_ADD; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check_eq("pre_rst_done_out", out, 8'h05);
    rst = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check_eq("rst_done_valid", out_valid, 0);
    check_eq("rst_done_out", out, 0);
    check_eq("rst_done_state", dbg_state, ST_IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_calculator.md
SEQ_CALCULATOR -- requirements
Module: seq_calculator

Interface
REQ-001 Parameter W, default 4: operand width in bits; legal range 2..32.
REQ-002 Parameter OW, default 2*W: result width; fixed at 2*W and not overridden.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 a  in  W  operand A, unsigned.
REQ-006 b  in  W  operand B, unsigned.
REQ-007 oper  in  3  opcode.
REQ-008 in_valid  in  1  a, b and oper are valid this cycle.
REQ-009 in_ready  out  1  block accepts an operation this cycle.
REQ-010 out  out  OW  result.
REQ-011 err  out  1  result is an error (divide by zero); qualified by out_valid.
REQ-012 out_valid  out  1  out and err are valid.
REQ-013 out_ready  in  1  consumer takes the result this cycle.

Function
REQ-014 Opcodes: 000 add; 001 sub; 010 mul; 011 div; 100 and; 101 or; 110 xor; 111 cmp.
REQ-015 add: zero-extended a+b; carry appears in bit W.
REQ-016 sub: a-b in two's complement, sign-extended to OW bits.
REQ-017 mul: unsigned a*b, computed iteratively by shift-add, one bit per cycle.
REQ-018 div: out = {W'remainder, W'quotient}, computed by restoring division, one bit per cycle.
REQ-019 and/or/xor: bitwise result, zero-extended to OW.
REQ-020 cmp: out[2:0] = {a>b, a==b, a<b}; all other bits are 0.
REQ-021 An operation is accepted when in_valid and in_ready are both high; a, b and oper are captured at acceptance, and later input changes have no effect.
REQ-022 The FSM has three states: IDLE, BUSY, DONE.
REQ-023 IDLE: in_ready=1. On acceptance of mul or div with b!=0, go to BUSY; on acceptance of any other op, go to DONE.
REQ-024 BUSY: in_ready=0; a W-bit iteration counter runs; after exactly W cycles in BUSY, go to DONE.
REQ-025 DONE: out_valid=1 and in_ready=0; out and err are held stable until out_ready=1, then go to IDLE.
REQ-026 Latency, measured from the acceptance edge to out_valid=1: 1 cycle for single-cycle ops; W+1 cycles for mul and div.
REQ-027 Divide by zero: no BUSY phase; latency 1; out = all ones; err = 1.
REQ-028 err = 0 for every other result.
REQ-029 in_valid while in BUSY or DONE is ignored; no queueing.
REQ-030 out_ready while out_valid=0 has no effect.
REQ-031 A new operation is accepted no earlier than the cycle after the DONE-to-IDLE transition, so throughput is at most one op per 2 cycles.
REQ-032 All outputs are registered; there are no combinational paths from inputs to outputs.

Reset
REQ-033 While rst=1 at a clock edge: state = IDLE; out = 0; err = 0; out_valid = 0; counter = 0; in_ready = 1 from the first cycle after rst deasserts.
REQ-034 rst asserted in BUSY or DONE aborts the operation; the partial result is discarded and never presented.
REQ-035 rst has priority over all handshakes in the same cycle.

Structure
REQ-036 The opcode localparams, state encodings and the cmp bit positions live in a shared package/header, calc_defs, used by RTL and bench.
REQ-037 The iterative multiply/divide datapath (accumulator, shift register, counter) is one sub-module, calc_muldiv, with start/busy/done ports; add, sub, logic and cmp stay in the top.

Verification (W=4)
REQ-038 a=9, b=3, oper=000, then 001 -> out=0x0C then 0x06; err=0; each out_valid 1 cycle after acceptance.
REQ-039 a=3, b=9, oper=001 -> out=0xFA; a=9, b=3, oper=111 -> out=0x04.
REQ-040 a=9, b=3, oper=010 -> in_ready low for 4 BUSY cycles; out=0x1B (27) with out_valid on cycle 5.
REQ-041 a=9, b=3, oper=011 -> out=0x03 (rem 0, quot 3) on cycle 5; a=9, b=0, oper=011 -> out=0xFF, err=1 on cycle 1.
REQ-042 out_ready held low for 10 cycles after mul result -> out stable, in_ready=0 throughout, in_valid pulses ignored; release -> IDLE next cycle.
REQ-043 rst asserted in 2nd BUSY cycle of a mul -> next cycle out_valid=0, out=0, in_ready=1 after release; a following add 1+1 -> out=0x02.
